// File: rtl/trace_tag.sv
// Instruction trace tagger: follows each fetched instruction through the I/X/M/R
// stages with a unique 32-bit ID and reports stage entry, retirement and flush kills.
module trace_tag #(
  parameter logic [31:0] ID_INIT = 32'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_v,
  input  logic        stall,
  input  logic        flush,
  output logic        inst_v_i,
  output logic        inst_v_x,
  output logic        inst_v_m,
  output logic        inst_v_r,
  output logic [31:0] ci,
  output logic [31:0] cx,
  output logic [31:0] cm,
  output logic [31:0] cr,
  output logic        kill_v,
  output logic [31:0] ck,
  output logic [31:0] ret_cnt
);

  logic [31:0] next_id;
  logic        i_v, i_first;
  logic        x_v, x_first;
  logic        m_v, m_first;
  logic        r_v;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      next_id <= ID_INIT;
      i_v     <= 1'b0;
      i_first <= 1'b0;
      x_v     <= 1'b0;
      x_first <= 1'b0;
      m_v     <= 1'b0;
      m_first <= 1'b0;
      r_v     <= 1'b0;
      ci      <= 32'd0;
      cx      <= 32'd0;
      cm      <= 32'd0;
      cr      <= 32'd0;
      kill_v  <= 1'b0;
      ck      <= 32'd0;
      ret_cnt <= 32'd0;
    end else begin
      // M -> R: M never stalls, so its occupant always leaves after one cycle
      r_v    <= m_v;
      kill_v <= 1'b0;
      if (m_v) begin
        cr      <= cm;
        ret_cnt <= ret_cnt + 32'd1;
      end
      if (flush) begin
        // X -> M survives the redirect; the I occupant and the fetch are dropped
        m_v     <= x_v;
        m_first <= x_v;
        if (x_v) cm <= cx;
        x_v     <= 1'b0;
        x_first <= 1'b0;
        i_v     <= 1'b0;
        i_first <= 1'b0;
        kill_v  <= i_v;
        if (i_v) ck <= ci;
      end else if (stall) begin
        m_v     <= 1'b0;
        m_first <= 1'b0;
        x_first <= 1'b0;
        i_first <= 1'b0;
      end else begin
        // I -> X -> M shift, new fetch enters I and consumes an ID
        m_v     <= x_v;
        m_first <= x_v;
        if (x_v) cm <= cx;
        x_v     <= i_v;
        x_first <= i_v;
        if (i_v) cx <= ci;
        i_v     <= if_v;
        i_first <= if_v;
        if (if_v) begin
          ci      <= next_id;
          next_id <= next_id + 32'd1;
        end
      end
    end
  end

  assign inst_v_i = i_v & i_first;
  assign inst_v_x = x_v & x_first;
  assign inst_v_m = m_v & m_first;
  assign inst_v_r = r_v;

endmodule

// File: tb/tb_trace_tag.sv
// Scoreboard bench for trace_tag: a transaction model pushes expected (id, cycle)
// events per stream; a negedge monitor pops them as the DUT pulses.
module tb_trace_tag;
  localparam logic [31:0] OFF = 32'hFFFF_FFFE;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic if_v = 1'b0, stall = 1'b0, flush = 1'b0;

  logic        inst_v_i, inst_v_x, inst_v_m, inst_v_r, kill_v;
  logic [31:0] ci, cx, cm, cr, ck, ret_cnt;
  logic        inst_v_i_w, inst_v_x_w, inst_v_m_w, inst_v_r_w, kill_v_w;
  logic [31:0] ci_w, cx_w, cm_w, cr_w, ck_w, ret_cnt_w;

  trace_tag dut (
    .clk(clk), .reset(reset), .if_v(if_v), .stall(stall), .flush(flush),
    .inst_v_i(inst_v_i), .inst_v_x(inst_v_x), .inst_v_m(inst_v_m), .inst_v_r(inst_v_r),
    .ci(ci), .cx(cx), .cm(cm), .cr(cr), .kill_v(kill_v), .ck(ck), .ret_cnt(ret_cnt)
  );

  trace_tag #(.ID_INIT(OFF)) dut_w (
    .clk(clk), .reset(reset), .if_v(if_v), .stall(stall), .flush(flush),
    .inst_v_i(inst_v_i_w), .inst_v_x(inst_v_x_w), .inst_v_m(inst_v_m_w), .inst_v_r(inst_v_r_w),
    .ci(ci_w), .cx(cx_w), .cm(cm_w), .cr(cr_w), .kill_v(kill_v_w), .ck(ck_w), .ret_cnt(ret_cnt_w)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] id;
    int          cyc;
  } ent_t;

  ent_t        q[5][$];
  string       nm[5] = '{"i", "x", "m", "r", "k"};
  logic [31:0] last[5];
  int          n_chk = 0, n_err = 0, cyc = 0, exp_ret = 0;
  logic [31:0] nid, mi_id, mx_id;
  logic        mi_v, mx_v;
  bit          mon_en = 1'b0;
  ent_t        me;

  logic        v[5], vw[5];
  logic [31:0] c[5], cw[5];
  always_comb begin
    v[0] = inst_v_i;   v[1] = inst_v_x;   v[2] = inst_v_m;   v[3] = inst_v_r;   v[4] = kill_v;
    vw[0] = inst_v_i_w; vw[1] = inst_v_x_w; vw[2] = inst_v_m_w; vw[3] = inst_v_r_w; vw[4] = kill_v_w;
    c[0] = ci;   c[1] = cx;   c[2] = cm;   c[3] = cr;   c[4] = ck;
    cw[0] = ci_w; cw[1] = cx_w; cw[2] = cm_w; cw[3] = cr_w; cw[4] = ck_w;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input int s, input logic [31:0] id, input int at);
    ent_t e;
    e.id  = id;
    e.cyc = at;
    q[s].push_back(e);
  endtask

  // Transaction model: decides at each edge which IDs move, retire or get killed
  task automatic step(input logic fv, input logic st, input logic fl);
    @(negedge clk);
    if_v = fv; stall = st; flush = fl;
    @(posedge clk);
    cyc++;
    if (fl) begin
      if (mi_v) push(4, mi_id, cyc);
      if (mx_v) begin push(2, mx_id, cyc); push(3, mx_id, cyc + 1); end
      mi_v = 1'b0;
      mx_v = 1'b0;
    end else if (!st) begin
      if (mx_v) begin push(2, mx_id, cyc); push(3, mx_id, cyc + 1); end
      if (mi_v) push(1, mi_id, cyc);
      mx_v  = mi_v;
      mx_id = mi_id;
      mi_v  = fv;
      if (fv) begin
        mi_id = nid;
        push(0, nid, cyc);
        nid = nid + 32'd1;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    reset = 1'b0; if_v = 1'b0; stall = 1'b0; flush = 1'b0;
    #1;
    for (int s = 0; s < 5; s++) begin
      check({nm[s], "_v_rst"}, 32'(v[s]), 32'd0);
      check({nm[s], "_id_rst"}, c[s], 32'd0);
      q[s].delete();
      last[s] = 32'd0;
    end
    check("ret_cnt_rst", ret_cnt, 32'd0);
    check("ret_cnt_w_rst", ret_cnt_w, 32'd0);
    mi_v = 1'b0; mx_v = 1'b0; nid = 32'd0; exp_ret = 0;
    mon_en = 1'b1;
    @(posedge clk); cyc++;
    @(posedge clk); cyc++;
    #2 reset = 1'b1;
  endtask

  task automatic drain_check();
    repeat (5) step(1'b0, 1'b0, 1'b0);
    for (int s = 0; s < 5; s++) check({nm[s], "_left"}, 32'(q[s].size()), 32'd0);
    check("ret_cnt_end", ret_cnt, 32'(exp_ret));
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      for (int s = 0; s < 5; s++) begin
        check({nm[s], "_v_wide"}, 32'(vw[s]), 32'(v[s]));
        if (v[s]) begin
          if (q[s].size() == 0) begin
            check({nm[s], "_unexpected"}, 32'(v[s]), 32'd0);
          end else begin
            me = q[s].pop_front();
            check({nm[s], "_id"}, c[s], me.id);
            check({nm[s], "_cycle"}, 32'(cyc), 32'(me.cyc));
            check({nm[s], "_id_wide"}, cw[s], me.id + OFF);
            last[s] = me.id;
            if (s == 3) begin
              exp_ret++;
              check("ret_cnt", ret_cnt, 32'(exp_ret));
              check("ret_cnt_w", ret_cnt_w, 32'(exp_ret));
            end
          end
        end else begin
          check({nm[s], "_hold"}, c[s], last[s]);
        end
      end
    end
  end

  initial begin
    do_reset();
    // three back-to-back fetches after reset
    repeat (3) step(1'b1, 1'b0, 1'b0);
    repeat (4) step(1'b0, 1'b0, 1'b0);
    check("ret_cnt_three", ret_cnt, 32'd3);
    // stall with an occupant in I and X
    repeat (3) step(1'b1, 1'b0, 1'b0);
    repeat (2) step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    repeat (4) step(1'b0, 1'b0, 1'b0);
    // flush with I and X occupied and a fetch pending
    repeat (2) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    repeat (4) step(1'b0, 1'b0, 1'b0);
    // stall and flush together
    repeat (2) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    repeat (4) step(1'b0, 1'b0, 1'b0);
    // flush while I is empty
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b0, 1'b0);
    // random traffic
    repeat (300)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 7) == 0));
    drain_check();
    // reset with three instructions in flight
    repeat (3) step(1'b1, 1'b0, 1'b0);
    do_reset();
    repeat (2) step(1'b1, 1'b0, 1'b0);
    drain_check();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/trace_tag.md
TRACE_TAG -- requirements
Module: trace_tag

Interface
REQ-001 SHALL have parameter: ID_INIT, 0, value loaded into the ID counter at reset.
REQ-002 SHALL have port: clk  input  1  clock; all state updates on the rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: if_v  input  1  an instruction is presented for entry into stage I this cycle.
REQ-005 SHALL have port: stall  input  1  hold stages I and X; insert a bubble into M.
REQ-006 SHALL have port: flush  input  1  the instruction in X redirects the PC; younger instructions are killed.
REQ-007 SHALL have ports: inst_v_i, inst_v_x, inst_v_m, inst_v_r  output  1 each  an instruction occupies that stage for its first cycle.
REQ-008 SHALL have ports: ci, cx, cm, cr  output  32 (int)  ID of the instruction flagged by the matching inst_v_*.
REQ-009 SHALL have ports: kill_v  output  1, ck  output  32  one-cycle pulse and the ID of the instruction discarded by flush.
REQ-010 SHALL have port: ret_cnt  output  32  count of retired instructions.

Function
REQ-011 SHALL hold per-stage state (valid, id, first) for I, X and M, and a one-cycle R slot (valid, id).
REQ-012 SHALL hold an ID counter next_id; on I-entry it assigns next_id to the entering instruction, then increments modulo 2^32.
REQ-013 Normal edge (!stall, !flush): R<=M, M<=X, X<=I, I<=if_v; the ID is consumed only if if_v=1.
REQ-014 Stall edge (stall, !flush): I and X hold with first cleared, M<=bubble, R<=M, if_v ignored, no ID consumed.
REQ-015 Flush edge (flush=1, stall ignored): R<=M, M<=X, X<=bubble, I<=bubble, if_v ignored, no ID consumed.
REQ-016 Flush edge with a valid I occupant: kill_v=1 and ck=id of that occupant in the next cycle.
REQ-017 Flush edge with I empty: kill_v SHALL remain 0.
REQ-018 inst_v_s SHALL equal valid&first of stage s; c* SHALL equal the stage id and SHALL be undefined-free (hold the last id when inst_v_s=0).
REQ-019 inst_v_r SHALL be a registered one-cycle pulse when a valid M occupant leaves M; M never stalls.
REQ-020 ret_cnt SHALL increment by 1 on each inst_v_r pulse, wrapping 0xFFFFFFFF->0.
REQ-021 Latency without stall or flush: if_v at edge k gives inst_v_i in cycle k+1, inst_v_x in k+2, inst_v_m in k+3 and inst_v_r in k+4, all with the same ID.
REQ-022 next_id wraps 0xFFFFFFFF->0x00000000 with no gap or repeat.
REQ-023 Every ID assigned SHALL produce exactly one inst_v_r or one kill_v pulse, never both.
REQ-024 All outputs SHALL be registered; there is no combinational path from inputs to outputs.

Reset
REQ-025 reset=0 SHALL asynchronously clear all valid and first flags, inst_v_*, kill_v, c*, ck and ret_cnt to 0, and load next_id=ID_INIT.
REQ-026 Reset asserted mid-operation SHALL discard in-flight instructions without kill or retire pulses.
REQ-027 After reset deasserts, the first if_v SHALL receive ID_INIT.

Verification
REQ-028 Reset, then if_v=1 for 3 edges -> inst_v_i cycles 1-3 with ci=0,1,2, and inst_v_r cycles 4-6 with cr=0,1,2; ret_cnt=3.
REQ-029 ID 5 in I, stall=1 for 2 edges -> inst_v_i for 1 cycle only, 2 M bubbles, ID 6 is not assigned until stall=0; inst_v_x with cx=5 after release.
REQ-030 ID 7 in X, ID 8 in I, flush with if_v=1 -> kill_v=1 with ck=8, ID 7 reaches M then R, next fetched instruction gets ID 9.
REQ-031 stall=1 and flush=1 on the same edge -> flush behaviour per REQ-015, and I/X are not held.
REQ-032 ID_INIT=0xFFFFFFFE, 3 fetches -> ci=0xFFFFFFFE, 0xFFFFFFFF, 0x00000000.
REQ-033 reset pulsed low while 3 instructions are in flight -> all outputs 0 immediately, no R or kill pulses, next ci=ID_INIT.
